// File: rtl/rev_mac_pe_seq.sv
// rev_mac_pe_seq: sequenced multiply/accumulate engine with an uncompute check on
// each datapath stage, operand/result buffers and fault-injection hooks.
module rev_mac_pe_seq #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int ACCW  = 2*DW + AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            start,
  input  logic            mode,
  input  logic [AW:0]     len,
  input  logic            inj_mult,
  input  logic            inj_add,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [ACCW-1:0] rd_data,
  output logic            rd_valid,
  output logic            busy,
  output logic            done,
  output logic            err_mult,
  output logic            err_add,
  output logic [AW:0]     err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [AW:0] DRAIN_LAST = (AW+1)'(2);
  localparam logic [AW:0] ONE_L      = (AW+1)'(1);

  state_t            state_r, state_s;
  logic [AW:0]       cnt_r, len_r, len_eff_s;
  logic              mode_r;
  logic              idle_s, start_ok_s, issue_s;

  logic [2*DW-1:0]   op_mem [DEPTH];
  logic [ACCW-1:0]   res_mem [DEPTH];

  logic              v0_r, v1_r, v2_r;
  logic [AW-1:0]     idx0_r, idx1_r, idx2_r;
  logic [2*DW-1:0]   q0_r;
  logic [DW-1:0]     a1_r, b1_r;
  logic [2*DW-1:0]   p2_r;
  logic [DW-1:0]     g2_r, b2_r;
  logic [ACCW-1:0]   acc_r;

  logic [2*DW-1:0]   prod_s, rev_prod_s;
  logic [DW-1:0]     arev_s;
  logic [ACCW-1:0]   p_ext_s, s_sum_s, s_new_s;
  logic              mult_mis_s, add_mis_s;

  logic              busy_r, done_r, rd_valid_r, err_mult_r, err_add_r;
  logic [ACCW-1:0]   rd_data_r;
  logic [AW:0]       err_cnt_r;

  assign idle_s     = (state_r == S_IDLE);
  assign start_ok_s = idle_s && start;
  assign issue_s    = (state_r == S_RUN);

  // Effective run length: 0 or anything past DEPTH means a full buffer.
  always_comb begin
    len_eff_s = len;
    if ((len == {(AW+1){1'b0}}) || (len > DEPTH_L)) begin
      len_eff_s = DEPTH_L;
    end else begin
      len_eff_s = len;
    end
  end

  // Next-state logic; cnt_r restarts on every state change.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_RUN;
        else       state_s = S_IDLE;
      end
      S_RUN: begin
        if (cnt_r == len_r - ONE_L) state_s = S_DRAIN;
        else                        state_s = S_RUN;
      end
      S_DRAIN: begin
        if (cnt_r == DRAIN_LAST) state_s = S_DONE;
        else                     state_s = S_DRAIN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register, run parameters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {(AW+1){1'b0}};
      len_r   <= DEPTH_L;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) cnt_r <= {(AW+1){1'b0}};
      else                    cnt_r <= cnt_r + ONE_L;
      if (start_ok_s) begin
        len_r  <= len_eff_s;
        mode_r <= mode;
      end
      busy_r <= (state_s == S_RUN) || (state_s == S_DRAIN);
      done_r <= (state_s == S_DONE);
    end
  end

  // Forward datapath and both uncompute checks; inject hooks corrupt stored values.
  always_comb begin
    prod_s     = {{DW{1'b0}}, a1_r} * {{DW{1'b0}}, b1_r};
    arev_s     = g2_r ^ b2_r;
    rev_prod_s = {{DW{1'b0}}, arev_s} * {{DW{1'b0}}, b2_r};
    p_ext_s    = {{AW{1'b0}}, p2_r};
    if (mode_r) s_sum_s = acc_r + p_ext_s;
    else        s_sum_s = p_ext_s;
    s_new_s    = s_sum_s ^ {{(ACCW-1){1'b0}}, inj_add};
    mult_mis_s = v2_r && (rev_prod_s != p2_r);
    if (mode_r) add_mis_s = v2_r && ((s_new_s - acc_r) != p_ext_s);
    else        add_mis_s = v2_r && (s_new_s != p_ext_s);
  end

  // Operand buffer: IDLE-only writes, stage-0 synchronous read.
  always_ff @(posedge clk) begin
    if (idle_s && wr_en) op_mem[wr_addr] <= wr_data;
    if (issue_s)         q0_r <= op_mem[cnt_r[AW-1:0]];
  end

  // Pipeline stages 1 and 2 with valid/index tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_r   <= 1'b0;
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      idx0_r <= {AW{1'b0}};
      idx1_r <= {AW{1'b0}};
      idx2_r <= {AW{1'b0}};
      a1_r   <= {DW{1'b0}};
      b1_r   <= {DW{1'b0}};
      p2_r   <= {(2*DW){1'b0}};
      g2_r   <= {DW{1'b0}};
      b2_r   <= {DW{1'b0}};
    end else begin
      v0_r   <= issue_s;
      idx0_r <= cnt_r[AW-1:0];
      v1_r   <= v0_r;
      idx1_r <= idx0_r;
      a1_r   <= q0_r[DW-1:0];
      b1_r   <= q0_r[2*DW-1:DW];
      v2_r   <= v1_r;
      idx2_r <= idx1_r;
      p2_r   <= prod_s ^ {{(2*DW-1){1'b0}}, inj_mult};
      g2_r   <= a1_r ^ b1_r;
      b2_r   <= b1_r;
    end
  end

  // Stage 3 commit into the result buffer.
  always_ff @(posedge clk) begin
    if (!rst && v2_r) res_mem[idx2_r] <= s_new_s;
  end

  // Accumulator and error bookkeeping, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      acc_r      <= {ACCW{1'b0}};
      err_mult_r <= 1'b0;
      err_add_r  <= 1'b0;
      err_cnt_r  <= {(AW+1){1'b0}};
    end else if (v2_r) begin
      if (mode_r) acc_r <= s_new_s;
      err_mult_r <= err_mult_r | mult_mis_s;
      err_add_r  <= err_add_r | add_mis_s;
      if ((mult_mis_s || add_mis_s) && (err_cnt_r != {(AW+1){1'b1}})) begin
        err_cnt_r <= err_cnt_r + ONE_L;
      end
    end
  end

  // Result read port, IDLE only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= {ACCW{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (idle_s && rd_en) begin
      rd_data_r  <= res_mem[rd_addr];
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err_mult = err_mult_r;
  assign err_add  = err_add_r;
  assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_rev_mac_pe_seq.sv
// Self-checking bench for rev_mac_pe_seq: directed scenarios plus randomized runs,
// checked every cycle against a run-level arithmetic model.
module tb_rev_mac_pe_seq;
  localparam int DW = 8, DEPTH = 16, AW = 4, ACCW = 20;

  logic clk = 1'b0;
  logic rst, wr_en, start, mode, inj_mult, inj_add, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [2*DW-1:0] wr_data;
  logic [AW:0] len;
  logic [ACCW-1:0] rd_data;
  logic rd_valid, busy, done, err_mult, err_add;
  logic [AW:0] err_cnt;

  rev_mac_pe_seq #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mode(mode), .len(len), .inj_mult(inj_mult), .inj_add(inj_add),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err_mult(err_mult), .err_add(err_add), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [15:0] op_m [DEPTH];
  logic [63:0] res_m [DEPTH];
  bit          res_k [DEPTH];
  bit run_act = 1'b0;
  int run_t = 0, run_l = 0;
  logic [63:0] rv_exp [int];
  bit          rv_kn  [int];
  int err_from = 1 << 30;
  bit exp_em = 1'b0, exp_ea = 1'b0;
  int exp_ec = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_idle(int c);
    return !(run_act && c >= run_t + 1 && c <= run_t + run_l + 4);
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, run_act && cyc >= run_t + 1 && cyc <= run_t + run_l + 3);
      check("done", done, run_act && cyc == run_t + run_l + 4);
      check("rd_valid", rd_valid, rv_exp.exists(cyc));
      if (rv_exp.exists(cyc) && rv_kn[cyc]) check("rd_data", rd_data, rv_exp[cyc]);
      if (cyc >= err_from) begin
        check("err_mult", err_mult, exp_em);
        check("err_add", err_add, exp_ea);
        check("err_cnt", err_cnt, exp_ec);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    if (run_act && cyc <= run_t + run_l + 4)
      for (int i = 0; i < run_l; i++) res_k[i] = 1'b0;
    run_act = 1'b0;
    rv_exp.delete();
    rv_kn.delete();
    exp_em = 1'b0; exp_ea = 1'b0; exp_ec = 0;
    err_from = cyc;
  endtask

  task automatic set_write(int a, logic [15:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    if (m_idle(cyc)) op_m[a] = d;
  endtask

  task automatic do_write(int a, logic [15:0] d);
    set_write(a, d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic begin_start(bit md, int ln, bit kn, bit em, bit ea, int ec);
    int c;
    logic [63:0] acc, p;
    c = cyc;
    acc = 64'd0;
    start = 1'b1; mode = md; len = (AW+1)'(ln);
    if (m_idle(c)) begin
      run_act = 1'b1;
      run_t = c;
      run_l = (ln == 0 || ln > DEPTH) ? DEPTH : ln;
      for (int i = 0; i < run_l; i++) begin
        p = 64'(op_m[i][7:0]) * 64'(op_m[i][15:8]);
        acc = acc + p;
        res_m[i] = md ? acc : p;
        res_k[i] = kn;
      end
      err_from = c + run_l + 4;
      exp_em = em; exp_ea = ea; exp_ec = ec;
    end
  endtask

  task automatic wait_run(bit poke);
    while (run_act && cyc <= run_t + run_l + 4) begin
      if (poke) begin
        wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, 15));
        wr_data = 16'($urandom());
        rd_en = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom_range(0, 15));
        start = (cyc == run_t + run_l + 4) ? 1'b1 : 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1)); len = (AW+1)'($urandom_range(0, 31));
      end
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0; start = 1'b0;
  endtask

  task automatic run(bit md, int ln, bit poke);
    begin_start(md, ln, 1'b1, 1'b0, 1'b0, 0);
    step();
    start = 1'b0;
    wait_run(poke);
  endtask

  task automatic do_read(int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    if (m_idle(cyc)) begin
      rv_exp[cyc + 1] = res_m[a];
      rv_kn[cyc + 1]  = res_k[a];
    end
    step();
    rd_en = 1'b0;
  endtask

  task automatic read_lit(string name, int a, logic [63:0] lit);
    do_read(a);
    @(negedge clk);
    check(name, rd_valid, 1'b1);
    check(name, rd_data, lit);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; mode = 1'b0; inj_mult = 1'b0; inj_add = 1'b0;
    rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; len = '0;
    do_reset();
    repeat (2) step();

    // Mode 0 on the four reference entries ({b,a})
    do_write(0, {8'd5, 8'd3});
    do_write(1, {8'd255, 8'd255});
    do_write(2, {8'd7, 8'd0});
    do_write(3, {8'd16, 8'd16});
    run(1'b0, 4, 1'b0);
    read_lit("m0_r0", 0, 64'd15);
    read_lit("m0_r1", 1, 64'd65025);
    read_lit("m0_r2", 2, 64'd0);
    read_lit("m0_r3", 3, 64'd256);

    // Mode 1 twice: the accumulator restarts each run
    for (int k = 0; k < 2; k++) begin
      run(1'b1, 4, 1'b0);
      read_lit("m1_r0", 0, 64'd15);
      read_lit("m1_r1", 1, 64'd65040);
      read_lit("m1_r2", 2, 64'd65040);
      read_lit("m1_r3", 3, 64'd65296);
    end

    // len = 0 means the full buffer
    for (int i = 0; i < DEPTH; i++) do_write(i, {8'd255, 8'd255});
    run(1'b1, 0, 1'b0);
    read_lit("len0_r15", 15, 64'd1040400);

    // inj_mult held for the whole run
    inj_mult = 1'b1;
    begin_start(1'b1, 4, 1'b0, 1'b1, 1'b0, 4);
    step(); start = 1'b0;
    wait_run(1'b0);
    inj_mult = 1'b0;

    // inj_add for exactly one cycle, while entry 1 enters stage 3
    begin_start(1'b1, 4, 1'b0, 1'b0, 1'b1, 1);
    step(); start = 1'b0;
    repeat (4) step();
    inj_add = 1'b1;
    step();
    inj_add = 1'b0;
    wait_run(1'b0);

    // Next start clears the flags
    run(1'b0, 4, 1'b0);
    read_lit("clean_r0", 0, 64'd65025);

    // Same-cycle write and start: run sees the new entry
    set_write(0, {8'd9, 8'd10});
    begin_start(1'b0, 1, 1'b1, 1'b0, 1'b0, 0);
    step(); wr_en = 1'b0; start = 1'b0;
    wait_run(1'b0);
    read_lit("wr_start", 0, 64'd90);

    // Ignored requests while busy, then read everything back
    run(1'b1, 16, 1'b1);
    for (int i = 0; i < DEPTH; i++) do_read(i);
    run(1'b0, 16, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_read(i);

    // Reset mid-run: no done pulse afterwards
    begin_start(1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
    step(); start = 1'b0;
    repeat (6) step();
    do_reset();
    repeat (25) step();

    // Randomized runs
    for (int r = 0; r < 24; r++) begin
      int nw;
      nw = int'($urandom_range(0, 5));
      for (int k = 0; k < nw; k++) do_write(int'($urandom_range(0, 15)), 16'($urandom()));
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < run_l; i++) do_read(i);
      step();
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rev_mac_pe_seq.md
# rev_mac_pe_seq

Parametrised successor to the single-lane reversible PE: a sequenced multiply/accumulate engine with a forward datapath, an uncompute check on each stage, an input operand buffer and an output result buffer. It sits behind the SPI slave's register/memory port the same way the current PE does. It generalises operand width and buffer depth, and adds:
- a running-accumulate mode,
- a programmable run length,
- an error counter,
- fault-injection hooks for exercising the reversibility checks.

## Interface
- `DW`, 8: operand width; each entry is {b, a}, 2·DW bits.
- `DEPTH`, 16: entries per buffer; power of two, ≥2.
- `AW`, $clog2(DEPTH): buffer address width.
- `ACCW`, 2·DW+AW: result width.
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write operand entry, honoured only in IDLE.
- `wr_addr`  in  AW  operand address.
- `wr_data`  in  2·DW  {b[DW-1:0], a[DW-1:0]}.
- `start`  in  1  begin a run, honoured only in IDLE.
- `mode`  in  1  0 = product only, 1 = running accumulate; sampled with start.
- `len`  in  AW+1  number of entries to process; sampled with start; 0 or >DEPTH means DEPTH.
- `inj_mult`  in  1  fault hook: flips bit 0 of the stored product in stage 2.
- `inj_add`  in  1  fault hook: flips bit 0 of the stored sum in stage 3.
- `rd_en`  in  1  result read request, honoured only in IDLE.
- `rd_addr`  in  AW  result address.
- `rd_data`  out  ACCW  result; valid when rd_valid.
- `rd_valid`  out  1  one cycle after an honoured rd_en.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  single-cycle pulse at run completion.
- `err_mult`  out  1  sticky; a multiplier uncompute mismatch occurred.
- `err_add`  out  1  sticky; an adder uncompute mismatch occurred.
- `err_cnt`  out  AW+1  entries with any mismatch in the current/last run; saturates at all-ones.

## Operation
- **States:** IDLE → RUN → DRAIN → DONE → IDLE.
  - IDLE → RUN on start. This also clears acc, err_mult, err_add and err_cnt, and latches mode and the effective len (L).
  - RUN lasts exactly L cycles. It issues operand-buffer reads at addresses 0..L-1, one per cycle.
  - DRAIN lasts 3 cycles. DONE lasts 1 cycle.
- **Pipeline, per entry i:**
  - Stage 0: synchronous buffer read.
  - Stage 1: register {a, b}.
  - Stage 2: register p = a·b (2·DW bits), g = a^b, and b.
  - Stage 3: register s, acc_in and p. In mode 1, s = acc_in + p with acc ← s. In mode 0, s = zero-extended p. The output-buffer write of s to address i happens on the same edge.
- **Multiplier check (stage 2 contents):** a_rev = g^b. Mismatch if a_rev·b ≠ p.
- **Adder check (stage 3 contents):** mismatch if s − acc_in ≠ p (mode 1), or s ≠ p (mode 0), modulo 2^ACCW.
- **Error reporting:** any mismatch sets the corresponding sticky flag. err_cnt increments once per entry that has a mismatch in either stage, counted when the entry leaves stage 3.
- **Overflow:** ACCW is sized so accumulation of DEPTH maximal products never overflows.
- **Ignored requests:**
  - wr_en, rd_en and start are ignored while not in IDLE; rd_valid stays 0 and no write occurs.
  - In DONE, start is ignored; it is accepted again from the following IDLE cycle.
- **Same-cycle write and start in IDLE:** the write commits first, and the run uses the new data.
- **Reset:** all state returns to IDLE. busy, done, rd_valid, err flags, err_cnt, rd_data and acc are all 0. Buffer contents are not reset.
- **Reset mid-run:** abandons the run. No done pulse, and the output buffer is partially written.

## Timing
- start sampled on the edge ending cycle T. busy = 1 for cycles T+1 .. T+L+3.
- Result i is written on the edge ending cycle T+i+4, so the last result is written on the edge ending T+L+3.
- done = 1 and busy = 0 in cycle T+L+4. A new start is accepted from T+L+5.
- err_cnt and the err flags are final when done is high.
- rd_en sampled at edge E gives rd_data and rd_valid during the cycle after E. Back-to-back reads are allowed, one per cycle.
- Inject hooks act on whichever entry occupies the stage in the cycle they are high.

## Test plan
- **Reset:** assert rst for 2 cycles mid-stream → busy, done, rd_valid, err_mult, err_add and err_cnt all 0 the cycle after; no done pulse follows.
- **Mode 0:** DW=8, load (a,b) = (3,5), (255,255), (0,7), (16,16); start with len=4 → done exactly at T+8; read back 15, 65025, 0, 256; err_cnt = 0.
- **Mode 1, same data:** → 15, 65040, 65040, 65296; a second run resets acc, giving identical results.
- **len=0:** all 16 entries = (255,255), mode 1 → done at T+20; result[15] = 1040400; no flags set.
- **Fault injection:**
  - inj_mult held through the run with len=4 → err_mult = 1, err_cnt = 4, err_add = 0.
  - inj_add high for exactly one cycle → err_add = 1, err_cnt = 1.
  - A following start clears both flags and err_cnt.
- **Protocol:**
  - start, wr_en and rd_en during busy → ignored; no rd_valid, and operands stay unchanged.
  - wr_en and start in the same IDLE cycle → the run uses the newly written entry.
